// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALUControl codes, legality check,
// slot state encoding and the registered response bundle.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Widest id/result any instance may need; instances use the low bits.
  localparam int RSP_ID_MAX_W   = 3;
  localparam int RSP_DATA_MAX_W = 64;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [RSP_ID_MAX_W-1:0]   id;
    logic [RSP_DATA_MAX_W-1:0] result;
    logic                      zero;
    logic                      illegal;
  } rsp_t;

  function automatic logic is_legal_alu_ctrl(input logic [3:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_AND) ||
           (ctrl == ALU_OR)  || (ctrl == ALU_SLT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr (wrapping), grants the first
// active request when enabled. With no grant, gnt_idx reports ptr.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;
  int   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !found && req[IDX_W'(j)]) begin
        gnt[IDX_W'(j)] = 1'b1;
        gnt_idx        = IDX_W'(j);
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with a single registered response slot.
// Optional ALU_SHARE_ERR_EN adds rsp_illegal, flagging a captured request with an unsupported code.
//
// state      | meaning
// SLOT_EMPTY | no response held; any valid request may be granted
// SLOT_FULL  | response held; a new grant only in a cycle where rsp_ready=1
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [4*NUM_REQ-1:0]      req_ctrl,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [3:0]                alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
`ifdef ALU_SHARE_ERR_EN
  output logic                      rsp_illegal,
`endif
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero
);

  slot_state_e         state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d, gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                can_accept, grant, legal;
  rsp_t                rsp_q, rsp_d;
  logic                unused_rsp_bits;

  assign can_accept = (state_q == SLOT_EMPTY) || rsp_ready;

  // Qualify with rst_n so no requester sees ready while reset is held.
  rr_arbiter #(.N(NUM_REQ), .IDX_W(ID_W)) u_rr (
    .req     (req_valid),
    .en      (can_accept && rst_n),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  // gnt_idx falls back to the pointer, so the ALU always sees a real requester.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        alu_a    = req_a[i*DATA_W +: DATA_W];
        alu_b    = req_b[i*DATA_W +: DATA_W];
        alu_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    legal   = is_legal_alu_ctrl(alu_ctrl);
    rsp_d   = '0;
    rsp_d.id      = RSP_ID_MAX_W'(gnt_idx);
    rsp_d.result  = legal ? RSP_DATA_MAX_W'(alu_result) : '0;
    rsp_d.zero    = legal ? alu_zero : 1'b1;
    rsp_d.illegal = !legal;
    if (grant) begin
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
    case (state_q)
      SLOT_EMPTY: if (grant) state_d = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !grant) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) rsp_q <= rsp_d;
    end
  end

  assign rsp_valid  = (state_q == SLOT_FULL);
  assign rsp_id     = rsp_q.id[ID_W-1:0];
  assign rsp_result = rsp_q.result[DATA_W-1:0];
  assign rsp_zero   = rsp_q.zero;
`ifdef ALU_SHARE_ERR_EN
  assign rsp_illegal = rsp_q.illegal;
`endif

  // Struct bits above ID_W/DATA_W (and illegal in the default build) are don't-care.
  assign unused_rsp_bits = ^rsp_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized run
// against a queue-free round-robin/slot reference model; a 3-requester instance checks wrap.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // two-requester instance
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [0:0]  rsp_id;
  logic        rsp_illegal;

  // three-requester instance
  logic [2:0]  w_req_valid, w_req_ready;
  logic [11:0] w_req_ctrl;
  logic [95:0] w_req_a, w_req_b;
  logic [31:0] w_alu_a, w_alu_b, w_alu_result, w_rsp_result;
  logic [3:0]  w_alu_ctrl;
  logic        w_alu_zero, w_rsp_valid, w_rsp_ready, w_rsp_zero;
  logic [1:0]  w_rsp_id;
  logic        w_rsp_illegal;

  always #5 clk = ~clk;

  // Behavioural ALU; unsupported codes produce a recognisable non-zero value.
  function automatic logic [32:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      default: return {1'b0, 32'hDEAD_BEEF};
    endcase
    return {(r == 32'd0), r};
  endfunction

  assign {alu_zero, alu_result}     = alu_fn(alu_ctrl, alu_a, alu_b);
  assign {w_alu_zero, w_alu_result} = alu_fn(w_alu_ctrl, w_alu_a, w_alu_b);

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32), .ID_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
`ifdef ALU_SHARE_ERR_EN
    .rsp_illegal(rsp_illegal),
`endif
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_share_arbiter #(.NUM_REQ(3), .DATA_W(32), .ID_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(w_req_valid), .req_ready(w_req_ready),
    .req_ctrl(w_req_ctrl), .req_a(w_req_a), .req_b(w_req_b),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_ctrl(w_alu_ctrl),
    .alu_result(w_alu_result), .alu_zero(w_alu_zero),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_id(w_rsp_id),
`ifdef ALU_SHARE_ERR_EN
    .rsp_illegal(w_rsp_illegal),
`endif
    .rsp_result(w_rsp_result), .rsp_zero(w_rsp_zero)
  );

`ifndef ALU_SHARE_ERR_EN
  assign rsp_illegal   = 1'b0;
  assign w_rsp_illegal = 1'b0;
`endif

  task automatic set_req(input int i, input logic v, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]     = v;
    req_ctrl[i*4+:4] = c;
    req_a[i*32+:32]  = a;
    req_b[i*32+:32]  = b;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    w_req_valid = '0; w_req_ctrl = '0; w_req_a = '0; w_req_b = '0; w_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req_valid = 2'b11;
    w_req_valid = 3'b111;
    #3;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (w_req_ready !== 3'b000) begin errors++; $display("FAIL reset_w_req_ready got=%b exp=000", w_req_ready); end
    checks++; if ({rsp_valid, rsp_id, rsp_zero} !== 3'b000 || rsp_result !== 32'd0)
      begin errors++; $display("FAIL reset_rsp got v=%b id=%0d z=%b r=%h exp all zero", rsp_valid, rsp_id, rsp_zero, rsp_result); end
    checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", rsp_illegal); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 4'b0010, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0)
      begin errors++; $display("FAIL single_rsp got v=%b id=%0d r=%0d z=%b exp v=1 id=0 r=12 z=0", rsp_valid, rsp_id, rsp_result, rsp_zero); end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_contention();
    int exp_g[4] = '{0, 1, 0, 1};
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 4'b0110, 32'd9, 32'd9);
    set_req(1, 1'b1, 4'b0111, 32'd3, 32'd4);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== (2'b01 << exp_g[c]))
        begin errors++; $display("FAIL contention_grant c=%0d got=%b exp=req%0d", c, req_ready, exp_g[c]); end
      @(posedge clk); #1;
      checks++;
      if (exp_g[c] == 0) begin
        if (rsp_id !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
          begin errors++; $display("FAIL contention_sub c=%0d got id=%0d r=%0d z=%b exp id=0 r=0 z=1", c, rsp_id, rsp_result, rsp_zero); end
      end else begin
        if (rsp_id !== 1'b1 || rsp_result !== 32'd1 || rsp_zero !== 1'b0)
          begin errors++; $display("FAIL contention_slt c=%0d got id=%0d r=%0d z=%b exp id=1 r=1 z=0", c, rsp_id, rsp_result, rsp_zero); end
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 4'b0010, 32'd1, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 4'b0110, 32'd10, 32'd3);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=00", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2 || rsp_zero !== 1'b0)
        begin errors++; $display("FAIL bp_hold c=%0d got v=%b id=%0d r=%0d exp v=1 id=0 r=2", c, rsp_valid, rsp_id, rsp_result); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd7)
      begin errors++; $display("FAIL bp_rsp got v=%b id=%0d r=%0d exp v=1 id=1 r=7", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_illegal();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 4'b1111, 32'd1, 32'd2);
    @(posedge clk); #1;
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b1)
      begin errors++; $display("FAIL illegal_mask got r=%h z=%b exp r=0 z=1", rsp_result, rsp_zero); end
`ifdef ALU_SHARE_ERR_EN
    checks++; if (rsp_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b exp=1", rsp_illegal); end
`endif
    @(negedge clk);
    set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'b0001, 32'h0000_F0F0, 32'h0000_0F0F);
    @(posedge clk); #1;
    checks++; if (rsp_result !== 32'h0000_FFFF || rsp_zero !== 1'b0 || rsp_id !== 1'b1)
      begin errors++; $display("FAIL illegal_follow got r=%h z=%b id=%0d exp r=ffff z=0 id=1", rsp_result, rsp_zero, rsp_id); end
`ifdef ALU_SHARE_ERR_EN
    checks++; if (rsp_illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got=%b exp=0", rsp_illegal); end
`endif
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 4'b0010, 32'd2, 32'd3);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_setup got=%b exp=1", rsp_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'd0)
      begin errors++; $display("FAIL rstmid_clear got v=%b r=%h exp v=0 r=0", rsp_valid, rsp_result); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'b0000, 32'hFF, 32'h0F);
    set_req(1, 1'b1, 4'b0001, 32'h1, 32'h2);
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got=%b exp=01", req_ready); end
    @(posedge clk); #1;
    checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'h0F)
      begin errors++; $display("FAIL rstmid_rsp got id=%0d r=%h exp id=0 r=f", rsp_id, rsp_result); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    w_req_valid = 3'b100;
    w_req_ctrl[8+:4] = 4'b0010; w_req_a[64+:32] = 32'd20; w_req_b[64+:32] = 32'd22;
    #1;
    checks++; if (w_req_ready !== 3'b100) begin errors++; $display("FAIL wrap_first got=%b exp=100", w_req_ready); end
    @(posedge clk); #1;
    checks++; if (w_rsp_id !== 2'd2 || w_rsp_result !== 32'd42)
      begin errors++; $display("FAIL wrap_rsp2 got id=%0d r=%0d exp id=2 r=42", w_rsp_id, w_rsp_result); end
    @(negedge clk);
    w_req_valid = 3'b101;
    w_req_ctrl[0+:4] = 4'b0110; w_req_a[0+:32] = 32'd50; w_req_b[0+:32] = 32'd8;
    #1;
    checks++; if (w_req_ready !== 3'b001) begin errors++; $display("FAIL wrap_second got=%b exp=001", w_req_ready); end
    @(posedge clk); #1;
    checks++; if (w_rsp_id !== 2'd0 || w_rsp_result !== 32'd42)
      begin errors++; $display("FAIL wrap_rsp0 got id=%0d r=%0d exp id=0 r=42", w_rsp_id, w_rsp_result); end
    @(negedge clk);
    w_req_valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] codes[7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1111, 4'b0011};
    int  ptr_m = 0;
    bit  mv = 0, mz = 0, mill = 0;
    int  mid = 0;
    logic [31:0] mres = '0;
    bit  held[2] = '{0, 0};
    int  g, sel;
    logic [32:0] r;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!held[i]) begin
          logic [31:0] a;
          a = $urandom_range(0, 15);
          set_req(i, ($urandom_range(0, 2) != 0), codes[$urandom_range(0, 6)], a,
                  ($urandom_range(0, 3) == 0) ? a : 32'($urandom_range(0, 15)));
        end
      end
      #1;
      g = -1;
      if (!mv || rsp_ready) begin
        for (int k = 0; k < 2; k++) begin
          if (g < 0 && req_valid[(ptr_m + k) % 2]) g = (ptr_m + k) % 2;
        end
      end
      checks++; if (req_ready !== ((g < 0) ? 2'b00 : (2'b01 << g)))
        begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp_grant=%0d", cyc, req_ready, g); end
      sel = (g < 0) ? ptr_m : g;
      checks++; if (alu_ctrl !== req_ctrl[sel*4+:4] || alu_a !== req_a[sel*32+:32] || alu_b !== req_b[sel*32+:32])
        begin errors++; $display("FAIL rand_alu_drive cyc=%0d got ctrl=%h a=%h exp req%0d", cyc, alu_ctrl, alu_a, sel); end
      for (int i = 0; i < 2; i++) held[i] = req_valid[i] && (g != i);
      @(posedge clk); #1;
      if (g >= 0) begin
        r    = alu_fn(req_ctrl[g*4+:4], req_a[g*32+:32], req_b[g*32+:32]);
        mill = !(req_ctrl[g*4+:4] inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111});
        mres = mill ? 32'd0 : r[31:0];
        mz   = mill ? 1'b1 : r[32];
        mid  = g;
        mv   = 1;
        ptr_m = (g + 1) % 2;
      end else if (rsp_ready) begin
        mv = 0;
      end
      checks++; if (rsp_valid !== mv) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, mv); end
      if (mv) begin
        checks++; if (rsp_id !== 1'(mid) || rsp_result !== mres || rsp_zero !== mz)
          begin errors++; $display("FAIL rand_rsp cyc=%0d got id=%0d r=%h z=%b exp id=%0d r=%h z=%b", cyc, rsp_id, rsp_result, rsp_zero, mid, mres, mz); end
`ifdef ALU_SHARE_ERR_EN
        checks++; if (rsp_illegal !== mill) begin errors++; $display("FAIL rand_illegal cyc=%0d got=%b exp=%b", cyc, rsp_illegal, mill); end
`endif
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
